// File: rtl/sccb_pkg.sv
// Shared definitions for the OV7670 SCCB 3-phase write master.
package sccb_pkg;

    // Transfer sequencer states; each non-idle, non-done state lasts one quarter tick.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_A,
        ST_START_B,
        ST_BIT,
        ST_STOP_A,
        ST_STOP_B,
        ST_STOP_C,
        ST_DONE
    } sccb_state_e;

    // Frame layout: ID byte, don't-care, reg addr, don't-care, value, don't-care.
    localparam int SCCB_BITS = 27;
    localparam int BIT_IDX_W = 5;

    localparam logic [BIT_IDX_W-1:0] DONTCARE_0 = BIT_IDX_W'(8);
    localparam logic [BIT_IDX_W-1:0] DONTCARE_1 = BIT_IDX_W'(17);
    localparam logic [BIT_IDX_W-1:0] DONTCARE_2 = BIT_IDX_W'(26);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(SCCB_BITS - 1);

    localparam logic [7:0] OV7670_WRITE_ID = 8'h42;

    localparam int                QUARTERS_PER_BIT = 4;
    localparam int                QTR_W            = 2;
    localparam logic [QTR_W-1:0]  QTR_LAST         = QTR_W'(QUARTERS_PER_BIT - 1);

    // True for the bit slots where the slave owns SIO_D and the master floats it.
    function automatic logic is_dontcare(input logic [BIT_IDX_W-1:0] idx);
        return (idx == DONTCARE_0) || (idx == DONTCARE_1) || (idx == DONTCARE_2);
    endfunction

    // Assemble the shifter image, MSB transmitted first; don't-care slots carry 0.
    function automatic logic [SCCB_BITS-1:0] build_frame(input logic [7:0]  id,
                                                         input logic [15:0] word);
        return {id, 1'b0, word[15:8], 1'b0, word[7:0], 1'b0};
    endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// Quarter-bit divider: counts 0..Q-1 and pulses tick on Q-1; clear holds it at 0.
module sccb_quarter_tick #(
    parameter int Q = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int              CNT_W = $clog2(Q + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(Q - 1);

    if (Q < 1) begin : g_q_invalid
        $error("sccb_quarter_tick: Q must be at least 1");
    end

    logic [CNT_W-1:0] cnt_q;

    assign tick = !clear && (cnt_q == LAST);

    // Free-running quarter counter, restarted whenever the writer is not mid-transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ov7670_sccb_writer.sv
// SCCB 3-phase write master: START, ID, reg addr, value, STOP per accepted word.
module ov7670_sccb_writer
    import sccb_pkg::*;
#(
    parameter int         CLK_FREQ_HZ  = 50_000_000,
    parameter int         SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0] DEVICE_ID    = OV7670_WRITE_ID
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data,
    output logic        ready,
    output logic        done,
    output logic        sio_c,
    output logic        sio_d_out,
    output logic        sio_d_oe
);
    localparam int Q = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);

    sccb_state_e            state_q, state_d;
    logic [SCCB_BITS-1:0]   shift_q;
    logic [BIT_IDX_W-1:0]   bit_q;
    logic [QTR_W-1:0]       qtr_q;

    logic tick;
    logic div_clear;
    logic accept;
    logic last_qtr;
    logic last_bit;

    assign accept    = (state_q == ST_IDLE) && start;
    assign div_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign last_qtr  = (qtr_q == QTR_LAST);
    assign last_bit  = (bit_q == LAST_BIT);

    sccb_quarter_tick #(
        .Q (Q)
    ) u_quarter_tick (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every bus phase advances on the quarter tick.
    always_comb begin
        // NOTE: defaulting every combinational output first guarantees no latch
        // is inferred on paths that do not assign it.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start)                          state_d = ST_START_A;
            ST_START_A: if (tick)                           state_d = ST_START_B;
            ST_START_B: if (tick)                           state_d = ST_BIT;
            ST_BIT:     if (tick && last_qtr && last_bit)   state_d = ST_STOP_A;
            ST_STOP_A:  if (tick)                           state_d = ST_STOP_B;
            ST_STOP_B:  if (tick)                           state_d = ST_STOP_C;
            ST_STOP_C:  if (tick)                           state_d = ST_DONE;
            ST_DONE:                                        state_d = ST_IDLE;
            default:                                        state_d = ST_IDLE;
        endcase
    end

    // Shifter and bit/quarter counters; data is captured only at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_q   <= '0;
            qtr_q   <= '0;
        end else if (accept) begin
            shift_q <= build_frame(DEVICE_ID, data);
            bit_q   <= '0;
            qtr_q   <= '0;
        end else if ((state_q == ST_BIT) && tick) begin
            if (last_qtr) begin
                qtr_q   <= '0;
                shift_q <= shift_q << 1;
                if (!last_bit) begin
                    bit_q <= bit_q + BIT_IDX_W'(1);
                end
            end else begin
                qtr_q <= qtr_q + QTR_W'(1);
            end
        end
    end

    // Output decode: bus levels follow state and quarter; SIO_D moves only while SIO_C is low
    // except at the START and STOP edges.
    always_comb begin
        ready     = 1'b0;
        done      = 1'b0;
        sio_c     = 1'b1;
        sio_d_out = 1'b1;
        sio_d_oe  = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_START_A: begin
                sio_d_out = 1'b0;
            end
            ST_START_B: begin
                sio_c     = 1'b0;
                sio_d_out = 1'b0;
            end
            ST_BIT: begin
                sio_c     = (qtr_q == QTR_W'(1)) || (qtr_q == QTR_W'(2));
                sio_d_out = shift_q[SCCB_BITS-1];
                sio_d_oe  = !is_dontcare(bit_q);
            end
            ST_STOP_A: begin
                sio_c     = 1'b0;
                sio_d_out = 1'b0;
            end
            ST_STOP_B: begin
                sio_d_out = 1'b0;
            end
            ST_STOP_C: begin
                sio_d_out = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ov7670_sccb_writer.sv
// Directed bench for ov7670_sccb_writer at Q=2, with a bus monitor feeding a scoreboard.
module tb_ov7670_sccb_writer;

    localparam int Q       = 2;
    localparam int LAT     = 113 * Q + 1;   // accepting cycle -> done cycle
    localparam int GAP     = 113 * Q + 2;   // accept-to-accept with start held high
    localparam int TIMEOUT = 1000;
    // Driven-slot mask: bit indices 8/17/26 (MSB first) are frame positions 18/9/0.
    localparam logic [26:0] OE_MASK = 27'h7FBFDFE;

    typedef struct packed {
        logic [26:0] d;
        logic [26:0] oe;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] data;
    logic        ready;
    logic        done;
    logic        sio_c;
    logic        sio_d_out;
    logic        sio_d_oe;

    ov7670_sccb_writer #(
        .CLK_FREQ_HZ  (800),
        .SCCB_FREQ_HZ (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data      (data),
        .ready     (ready),
        .done      (done),
        .sio_c     (sio_c),
        .sio_d_out (sio_d_out),
        .sio_d_oe  (sio_d_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor state (written only by the monitor process).
    frame_t      obs_q[$];
    int          acc_q[$];
    int          done_q[$];
    int          start_cnt = 0;
    int          stop_cnt  = 0;
    logic        prev_c = 1'b1;
    logic        prev_d = 1'b1;
    logic        in_xfer = 1'b0;
    int          nbits = 0;
    logic [26:0] fr_d, fr_oe;

    // Bus monitor: samples away from the active edge, decodes START/STOP and
    // collects the level seen on each SIO_C rising edge.
    always @(negedge clk) begin
        if (reset) begin
            in_xfer = 1'b0;
        end else begin
            if (start && ready) acc_q.push_back(cyc);
            if (done)           done_q.push_back(cyc);
            if (prev_c && sio_c && prev_d && !sio_d_out) begin
                start_cnt++;
                in_xfer = 1'b1;
                nbits   = 0;
                fr_d    = '0;
                fr_oe   = '0;
            end else if (prev_c && sio_c && !prev_d && sio_d_out) begin
                stop_cnt++;
            end else if (sio_c && !prev_c && in_xfer) begin
                fr_d  = {fr_d[25:0], sio_d_out};
                fr_oe = {fr_oe[25:0], sio_d_oe};
                nbits++;
                if (nbits == 27) begin
                    obs_q.push_back('{d: fr_d, oe: fr_oe});
                    in_xfer = 1'b0;
                end
            end
        end
        prev_c = sio_c;
        prev_d = sio_d_out;
    end

    // Scoreboard and counters (written only by the stimulus process).
    logic [26:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int nf = 0;
    int na = 0;
    int nd = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back({8'h42, 1'b0, w[15:8], 1'b0, w[7:0], 1'b0});
    endtask

    // Single-cycle request while the writer is idle.
    task automatic send(input logic [15:0] w, input bit scored);
        start = 1'b1;
        data  = w;
        if (scored) expect_word(w);
        step();
        start = 1'b0;
    endtask

    task automatic wait_dones(input string tag, input int n);
        int k;
        k = 0;
        while (done_q.size() < n && k < n * TIMEOUT) begin
            step();
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_q.size() >= n), 32'd1);
    endtask

    task automatic check_xfer(input string tag);
        check({tag, "_frame_present"}, 32'(obs_q.size() > nf && exp_q.size() > nf), 32'd1);
        if (obs_q.size() > nf && exp_q.size() > nf) begin
            check({tag, "_bits"}, 32'(obs_q[nf].d & OE_MASK), 32'(exp_q[nf] & OE_MASK));
            check({tag, "_oe"},   32'(obs_q[nf].oe), 32'(OE_MASK));
            nf++;
        end
        if (acc_q.size() > na && done_q.size() > nd) begin
            check({tag, "_latency"}, 32'(done_q[nd] - acc_q[na]), 32'(LAT));
            na++;
            nd++;
        end else begin
            check({tag, "_latency_present"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_idle_bus(input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready),     32'd1);
        check({tag, "_sio_c"}, 32'(sio_c),     32'd1);
        check({tag, "_sio_d"}, 32'(sio_d_out), 32'd1);
        check({tag, "_oe"},    32'(sio_d_oe),  32'd1);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    initial begin
        int d_before, f_before, s_before;
        reset = 1'b1;
        start = 1'b0;
        data  = '0;

        // 1: reset values
        repeat (3) step();
        check_idle_bus("reset");
        step();
        reset = 1'b0;
        step();

        // 2: COM7 reset write
        send(16'h1280, 1'b1);
        @(negedge clk);
        check("t2_ready_drops", 32'(ready), 32'd0);
        wait_dones("t2", nd + 1);
        check_xfer("t2");
        check("t2_starts", 32'(start_cnt), 32'd1);
        check("t2_stops",  32'(stop_cnt),  32'd1);
        step();
        check_idle_bus("t2_after");

        // 3: start held high across two transfers
        start = 1'b1;
        data  = 16'h0000;
        expect_word(16'h0000);
        step();
        data = 16'hFFFF;
        expect_word(16'hFFFF);
        begin
            int k;
            k = 0;
            while (acc_q.size() < na + 2 && k < 2 * TIMEOUT) begin
                step();
                k++;
            end
        end
        step();
        start = 1'b0;
        check("t3_two_accepts", 32'(acc_q.size()), 32'(na + 2));
        if (acc_q.size() >= na + 2)
            check("t3_gap", 32'(acc_q[na + 1] - acc_q[na]), 32'(GAP));
        wait_dones("t3", nd + 2);
        check_xfer("t3a");
        check_xfer("t3b");
        repeat (300) step();
        check("t3_no_extra_accept", 32'(acc_q.size()), 32'(na));
        check("t3_no_extra_done",   32'(done_q.size()), 32'(nd));

        // 4: data changes and start pulses mid-transfer are ignored
        send(16'h3A5C, 1'b1);
        repeat (100) step();
        data  = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        data  = 16'h0F0F;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_dones("t4", nd + 1);
        check_xfer("t4");
        repeat (300) step();
        check("t4_one_done",   32'(done_q.size()), 32'(nd));
        check("t4_one_accept", 32'(acc_q.size()),  32'(na));

        // 5: reset in bit 12 aborts without STOP or done; a fresh write then completes
        d_before = done_q.size();
        f_before = obs_q.size();
        s_before = stop_cnt;
        send(16'h5A3C, 1'b0);
        repeat (104) step();
        reset = 1'b1;
        step();
        check_idle_bus("t5_reset");
        step();
        reset = 1'b0;
        repeat (300) step();
        check("t5_no_done",  32'(done_q.size()), 32'(d_before));
        check("t5_no_frame", 32'(obs_q.size()),  32'(f_before));
        check("t5_no_stop",  32'(stop_cnt),      32'(s_before));
        na = acc_q.size();
        send(16'h1F04, 1'b1);
        wait_dones("t5", nd + 1);
        check_xfer("t5");

        // Bus-level totals over the whole run
        repeat (10) step();
        check("total_starts", 32'(start_cnt), 32'd6);
        check("total_stops",  32'(stop_cnt),  32'd5);
        check("total_frames", 32'(obs_q.size()), 32'(exp_q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
